// File: rtl/arm_control_unit.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch, decode,
// data-processing, load/store and branch, plus condition-flag storage.
module arm_control_unit (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ALUControl,
    output logic [1:0] ALUSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;
    logic [3:0] w_cmd;
    logic       w_n, w_z, w_c, w_v;
    logic       w_condex;
    logic [1:0] w_alu_op;
    logic       w_cmd_ok;
    logic       w_cmd_wr;
    logic       w_flag_upd;

    assign w_cmd = Funct[4:1];
    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign Flags = r_flags;
    assign State = r_state;

    always_comb begin
        w_condex = 1'b0;
        case (Cond)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = !w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = !w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = !w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = !w_v;
            4'b1000: w_condex = w_c && !w_z;
            4'b1001: w_condex = !w_c || w_z;
            4'b1010: w_condex = (w_n == w_v);
            4'b1011: w_condex = (w_n != w_v);
            4'b1100: w_condex = !w_z && (w_n == w_v);
            4'b1101: w_condex = w_z || (w_n != w_v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // CMP is a SUB that never writes a register; unknown cmds do nothing
    always_comb begin
        w_alu_op = 2'b00;
        w_cmd_ok = 1'b1;
        w_cmd_wr = 1'b1;
        case (w_cmd)
            4'b0100: w_alu_op = 2'b00;
            4'b0010: w_alu_op = 2'b01;
            4'b0000: w_alu_op = 2'b10;
            4'b1100: w_alu_op = 2'b11;
            4'b1010: begin
                w_alu_op = 2'b01;
                w_cmd_wr = 1'b0;
            end
            default: begin
                w_cmd_ok = 1'b0;
                w_cmd_wr = 1'b0;
            end
        endcase
    end

    assign w_flag_upd = (r_state == S_ALUWB) && w_condex && w_cmd_ok
                        && (Funct[0] || (w_cmd == 4'b1010));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (w_flag_upd) begin
                r_flags[3:2] <= ALUFlags[3:2];
                // logical ops keep the previous carry and overflow
                if (!w_alu_op[1])
                    r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        MemtoReg   = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ALUControl = 2'b00;
        ALUSrc     = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    w_next  = S_DECODE;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                S_DECODE: begin
                    case (Op)
                        2'b00:   w_next = S_EXEC;
                        2'b01:   w_next = S_MEMADR;
                        2'b10:   w_next = S_BRANCH;
                        default: w_next = S_FETCH;
                    endcase
                end
                S_EXEC, S_ALUWB: begin
                    w_next     = (r_state == S_EXEC) ? S_ALUWB : S_FETCH;
                    ALUControl = w_alu_op;
                    ALUSrc     = Funct[5] ? 2'b01 : 2'b00;
                    if (r_state == S_ALUWB && w_cmd_wr) begin
                        if (Rd == 4'd15) begin
                            PCSrc   = 1'b1;
                            PCWrite = w_condex;
                        end else begin
                            RegWrite = w_condex;
                        end
                    end
                end
                S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB: begin
                    ALUSrc = 2'b01;
                    ImmSrc = 2'b01;
                    case (r_state)
                        S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
                        S_MEMRD:  w_next = S_MEMWB;
                        default:  w_next = S_FETCH;
                    endcase
                    if (r_state == S_MEMWR) begin
                        RegSrc   = 2'b10;
                        MemWrite = w_condex;
                    end
                    if (r_state == S_MEMWB) begin
                        MemtoReg = 1'b1;
                        if (Rd == 4'd15) begin
                            PCSrc   = 1'b1;
                            PCWrite = w_condex;
                        end else begin
                            RegWrite = w_condex;
                        end
                    end
                end
                S_BRANCH: begin
                    RegSrc  = 2'b01;
                    ALUSrc  = 2'b01;
                    ImmSrc  = 2'b10;
                    PCSrc   = 1'b1;
                    PCWrite = w_condex;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_control_unit.sv
// Self-checking bench for arm_control_unit: directed scenarios plus
// random instructions compared against an instruction-level model.
module tb_arm_control_unit;

    logic       CLK;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       IRWrite, PCWrite, PCSrc, MemtoReg, MemWrite, RegWrite;
    logic [1:0] ALUControl, ALUSrc, ImmSrc, RegSrc;
    logic [3:0] Flags;
    logic [3:0] State;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic       pcs;
        logic       m2r;
        logic       mw;
        logic       rw;
        logic [1:0] alu;
        logic [1:0] asrc;
        logic [1:0] isrc;
        logic [1:0] rsrc;
    } ctl_t;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_flags;

    arm_control_unit dut (
        .CLK(CLK), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct),
        .Rd(Rd), .ALUFlags(ALUFlags), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .Flags(Flags), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic ctl_t obs_ctl();
        ctl_t o;
        o = {IRWrite, PCWrite, PCSrc, MemtoReg, MemWrite, RegWrite,
             ALUControl, ALUSrc, ImmSrc, RegSrc};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c,
                                     input logic [3:0] fl);
        logic n, z, cf, v;
        {n, z, cf, v} = fl;
        case (c)
            0: return z;
            1: return !z;
            2: return cf;
            3: return !cf;
            4: return n;
            5: return !n;
            6: return v;
            7: return !v;
            8: return cf && !z;
            9: return !cf || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU op requested by a data-processing command (ADD if unknown)
    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Run one instruction from FETCH; checks every cycle and the final flags.
    task automatic run_instr(input string tag, input logic [3:0] c,
                             input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic [3:0] af);
        int   seq[$];
        ctl_t e;
        logic x;
        logic wr_cmd;
        logic flag_cmd;
        logic [3:0] cmd;
        cmd = f[4:1];
        wr_cmd = (cmd == 4'b0100) || (cmd == 4'b0010) ||
                 (cmd == 4'b0000) || (cmd == 4'b1100);
        flag_cmd = wr_cmd || (cmd == 4'b1010);
        x = cond_ok(c, m_flags);
        Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
        case (op)
            2'b00: seq = '{0, 1, 2, 3};
            2'b01: seq = f[0] ? '{0, 1, 4, 5, 6} : '{0, 1, 4, 7};
            2'b10: seq = '{0, 1, 8};
            default: seq = '{0, 1};
        endcase
        #1;
        foreach (seq[i]) begin
            e = '0;
            case (seq[i])
                0: begin e.irw = 1; e.pcw = 1; end
                2, 3: begin
                    e.alu = alu_of(cmd);
                    e.asrc = f[5] ? 2'b01 : 2'b00;
                    if (seq[i] == 3 && wr_cmd) begin
                        if (rd == 15) begin e.pcs = 1; e.pcw = x; end
                        else e.rw = x;
                    end
                end
                4, 5, 6, 7: begin
                    e.asrc = 2'b01; e.isrc = 2'b01;
                    if (seq[i] == 7) begin e.rsrc = 2'b10; e.mw = x; end
                    if (seq[i] == 6) begin
                        e.m2r = 1;
                        if (rd == 15) begin e.pcs = 1; e.pcw = x; end
                        else e.rw = x;
                    end
                end
                8: begin
                    e.rsrc = 2'b01; e.asrc = 2'b01; e.isrc = 2'b10;
                    e.pcs = 1; e.pcw = x;
                end
                default: e = '0;
            endcase
            chk({tag, "_state"}, 32'(State), 32'(seq[i]));
            chk({tag, "_ctl"}, 32'(obs_ctl()), 32'(e));
            @(posedge CLK);
            #1;
        end
        if (op == 2'b00 && x && flag_cmd && (f[0] || cmd == 4'b1010)) begin
            m_flags[3:2] = af[3:2];
            if (alu_of(cmd) < 2) m_flags[1:0] = af[1:0];
        end
        chk({tag, "_end"}, 32'(State), 32'd0);
        chk({tag, "_flags"}, 32'(Flags), 32'(m_flags));
    endtask

    initial begin
        logic [3:0] cmds[5];
        logic [3:0] rc, rrd, raf, rcmd;
        logic [5:0] rf;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        reset = 1'b1;
        Cond = 4'hE; Op = 2'b11; Funct = '0; Rd = '0; ALUFlags = '0;
        m_flags = 4'b0000;
        #1;
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_ctl", 32'(obs_ctl()), 32'd0);
        chk("rst_flags", 32'(Flags), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_hold_ctl", 32'(obs_ctl()), 32'd0);
        reset = 1'b0;

        run_instr("add", 4'hE, 2'b00, 6'b0_0100_0, 4'd3, 4'b0000);
        run_instr("cmp", 4'hE, 2'b00, 6'b0_1010_1, 4'd0, 4'b0100);
        run_instr("beq_t", 4'h0, 2'b10, 6'b0, 4'd0, 4'b0000);
        run_instr("cmp0", 4'hE, 2'b00, 6'b0_1010_1, 4'd0, 4'b0000);
        run_instr("beq_f", 4'h0, 2'b10, 6'b0, 4'd0, 4'b0000);
        run_instr("bne", 4'h1, 2'b10, 6'b0, 4'd0, 4'b0000);
        run_instr("ldr", 4'hE, 2'b01, 6'b0_0000_1, 4'd2, 4'b0000);
        run_instr("str", 4'hE, 2'b01, 6'b0_0000_0, 4'd2, 4'b0000);
        run_instr("cmp3", 4'hE, 2'b00, 6'b0_1010_1, 4'd0, 4'b0011);
        run_instr("ands", 4'hE, 2'b00, 6'b0_0000_1, 4'd4, 4'b1011);
        run_instr("nv", 4'hF, 2'b00, 6'b0_0100_1, 4'd5, 4'b0101);
        run_instr("und", 4'hE, 2'b11, 6'b0, 4'd0, 4'b1111);
        run_instr("addpc", 4'hE, 2'b00, 6'b1_0100_0, 4'd15, 4'b0000);
        run_instr("ldrpc", 4'hE, 2'b01, 6'b0_0000_1, 4'd15, 4'b0000);

        for (int i = 0; i < 300; i++) begin
            rc = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) rc = 4'hE;
            rcmd = cmds[$urandom_range(0, 4)];
            if ($urandom_range(0, 5) == 0) rcmd = 4'($urandom);
            rf = {1'($urandom), rcmd, 1'($urandom)};
            rrd = 4'($urandom);
            raf = 4'($urandom);
            run_instr("rnd", rc, 2'($urandom), rf, rrd, raf);
        end

        Cond = 4'hE; Op = 2'b01; Funct = 6'b0; Rd = 4'd1;
        @(posedge CLK);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        chk("mw_state", 32'(State), 32'd7);
        chk("mw_on", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        m_flags = 4'b0000;
        #1;
        chk("mw_rst_mw", 32'(MemWrite), 32'd0);
        chk("mw_rst_state", 32'(State), 32'd0);
        chk("mw_rst_ctl", 32'(obs_ctl()), 32'd0);
        chk("mw_rst_flags", 32'(Flags), 32'd0);
        @(negedge CLK);
        Op = 2'b11;
        reset = 1'b0;
        #1;
        chk("rel_state", 32'(State), 32'd0);
        chk("rel_irw", 32'(IRWrite), 32'd1);
        @(posedge CLK);
        #1;
        chk("rel_decode", 32'(State), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        chk("rel_back", 32'(State), 32'd0);
        run_instr("post", 4'hE, 2'b00, 6'b0_0010_1, 4'd6, 4'b1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
